// File: rtl/riscv_enc_pkg.sv
// Shared RV32I encoding constants for the program loader and the control-unit
// decoders: opcodes, funct3/funct7 codes, request kinds, ALUControl codes,
// loader FSM state encoding, plus small helpers for immediate range checks.
package riscv_enc_pkg;

    // Major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    // funct3 codes
    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_LW      = 3'b010;
    localparam logic [2:0] F3_SW      = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    // funct7 codes
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    // Request kinds (6 and 7 are illegal)
    localparam logic [2:0] KIND_R     = 3'd0;
    localparam logic [2:0] KIND_I_ALU = 3'd1;
    localparam logic [2:0] KIND_LW    = 3'd2;
    localparam logic [2:0] KIND_SW    = 3'd3;
    localparam logic [2:0] KIND_BEQ   = 3'd4;
    localparam logic [2:0] KIND_JAL   = 3'd5;

    // ALUControl codes
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Loader FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ldr_state_e;

    // Returns {legal, funct3} for an ALUControl code.
    function automatic logic [3:0] alu_funct3(input logic [2:0] alu);
        logic [3:0] r;
        case (alu)
            ALU_ADD: r = {1'b1, F3_ADD_SUB};
            ALU_SUB: r = {1'b1, F3_ADD_SUB};
            ALU_AND: r = {1'b1, F3_AND};
            ALU_OR:  r = {1'b1, F3_OR};
            ALU_SLT: r = {1'b1, F3_SLT};
            default: r = {1'b0, 3'b000};
        endcase
        return r;
    endfunction

    // A 21-bit value fits N-bit signed when all bits above N-1 copy bit N-1.
    function automatic logic fits_s12(input logic [20:0] imm);
        return imm[20:11] == {10{imm[11]}};
    endfunction

    function automatic logic fits_s13(input logic [20:0] imm);
        return imm[20:12] == {9{imm[12]}};
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational encoder: field-level instruction request -> 32-bit RV32I word.
// Ports:
//   kind, alu          request kind and ALUControl code
//   rd, rs1, rs2       register indices (unused slots ignored)
//   imm                21-bit signed immediate (byte offset for BEQ/JAL)
//   word               encoded instruction
//   illegal            request cannot be encoded (bad kind/alu or imm out of range)
module instr_encoder
    import riscv_enc_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [2:0]  alu,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [20:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    logic       alu_ok;
    logic [2:0] f3;
    logic [6:0] f7;

    assign {alu_ok, f3} = alu_funct3(alu);
    assign f7 = (alu == ALU_SUB) ? F7_SUB : F7_BASE;

    always_comb begin
        word    = 32'h0;
        illegal = 1'b0;
        case (kind)
            KIND_R: begin
                illegal = !alu_ok;
                word    = {f7, rs2, rs1, f3, rd, OP_R};
            end
            KIND_I_ALU: begin
                // There is no subtract-immediate in RV32I.
                illegal = !alu_ok || (alu == ALU_SUB) || !fits_s12(imm);
                word    = {imm[11:0], rs1, f3, rd, OP_I_ALU};
            end
            KIND_LW: begin
                illegal = !fits_s12(imm);
                word    = {imm[11:0], rs1, F3_LW, rd, OP_LOAD};
            end
            KIND_SW: begin
                illegal = !fits_s12(imm);
                word    = {imm[11:5], rs2, rs1, F3_SW, imm[4:0], OP_STORE};
            end
            KIND_BEQ: begin
                illegal = !fits_s13(imm) || imm[0];
                word    = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BRANCH};
            end
            KIND_JAL: begin
                // Any 21-bit value fits; only alignment can fail.
                illegal = imm[0];
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts field-level instruction requests over valid/ready,
// encodes each to RV32I and writes the words sequentially into instruction
// memory starting at BASE_ADDR. One word per two cycles (LOAD then WRITE).
// Ports:
//   clk, reset_n                 clock; asynchronous active-low reset
//   start                        begin a load (honoured only in IDLE/DONE)
//   req_valid/req_ready          request handshake
//   req_kind..req_last           request fields; req_last ends the program
//   imem_we/imem_addr/imem_wdata instruction memory write port
//   count                        words written since start
//   full                         memory filled (count == 2**ADDR_W)
//   err                          sticky rejected-request flag, cleared by start
//   done                         load finished
module instr_encoder_loader
    import riscv_enc_pkg::*;
#(
    parameter int ADDR_W    = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_kind,
    input  logic [2:0]        req_alu,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [20:0]       req_imm,
    input  logic              req_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              err,
    output logic              done
);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

    ldr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              last_q, last_d;
    logic              err_q, err_d;

    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              accept;

    instr_encoder u_enc (
        .kind    (req_kind),
        .alu     (req_alu),
        .rd      (req_rd),
        .rs1     (req_rs1),
        .rs2     (req_rs2),
        .imm     (req_imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        count_d   = count_q;
        wdata_d   = wdata_q;
        last_d    = last_q;
        err_d     = err_q;
        req_ready = 1'b0;
        imem_we   = 1'b0;
        accept    = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    addr_d  = BASE;
                    count_d = '0;
                    err_d   = 1'b0;
                end
            end
            ST_LOAD: begin
                req_ready = (count_q != FULL_CNT);
                accept    = req_valid && req_ready;
                if (accept) begin
                    // A rejected request still completes the handshake but
                    // leaves the write pointer and program end untouched.
                    if (enc_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        wdata_d = enc_word;
                        last_d  = req_last;
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                imem_we = 1'b1;
                addr_d  = addr_q + 1'b1;
                count_d = count_q + 1'b1;
                if (last_q || (count_d == FULL_CNT)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE;
            count_q <= '0;
            wdata_q <= 32'h0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            wdata_q <= wdata_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign full       = (count_q == FULL_CNT);
    assign err        = err_q;
    assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a table of known encodings, randomized
// requests against a field-arithmetic reference model, and hand sequences for
// start/full/reset corner cases (second instance with ADDR_W=2 for full).
module tb_instr_encoder_loader;

    logic        clk = 1'b0;
    logic        reset_n;

    // Main instance (ADDR_W = 6)
    logic        start, req_valid, req_ready, req_last;
    logic [2:0]  req_kind, req_alu;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [20:0] req_imm;
    logic        imem_we, full, err, done;
    logic [5:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [6:0]  count;

    // Small instance (ADDR_W = 2)
    logic        d2_start, d2_valid, d2_ready, d2_last;
    logic [2:0]  d2_kind, d2_alu;
    logic [4:0]  d2_rd, d2_rs1, d2_rs2;
    logic [20:0] d2_imm;
    logic        d2_we, d2_full, d2_err, d2_done;
    logic [1:0]  d2_addr;
    logic [31:0] d2_wdata;
    logic [2:0]  d2_count;

    int n_checks = 0;
    int n_err    = 0;
    int exp_addr = 0;
    int exp_cnt  = 0;
    bit exp_err  = 0;

    always #5 clk = ~clk;

    instr_encoder_loader #(.ADDR_W(6), .BASE_ADDR(0)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_kind(req_kind), .req_alu(req_alu), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
        .req_last(req_last), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .full(full),
        .err(err), .done(done)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(d2_start),
        .req_valid(d2_valid), .req_ready(d2_ready),
        .req_kind(d2_kind), .req_alu(d2_alu), .req_rd(d2_rd),
        .req_rs1(d2_rs1), .req_rs2(d2_rs2), .req_imm(d2_imm),
        .req_last(d2_last), .imem_we(d2_we), .imem_addr(d2_addr),
        .imem_wdata(d2_wdata), .count(d2_count), .full(d2_full),
        .err(d2_err), .done(d2_done)
    );

    typedef struct {
        logic [2:0]  kind;
        logic [2:0]  alu;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        int          imm;
        logic        last;
        logic [31:0] word;
        bit          ill;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Reference encoder built from the instruction-format bit positions.
    function automatic void model(input int k, input int a, input int rd, input int rs1,
                                  input int rs2, input int imm,
                                  output logic [31:0] w, output bit ill);
        logic [31:0] u, r1, r2, d, f3;
        bit alu_ok;
        u = 32'(imm); r1 = 32'(rs1); r2 = 32'(rs2); d = 32'(rd);
        alu_ok = 1; f3 = 0;
        case (a)
            0, 1: f3 = 0;
            2:    f3 = 7;
            3:    f3 = 6;
            5:    f3 = 2;
            default: alu_ok = 0;
        endcase
        w = 0; ill = 0;
        case (k)
            0: begin
                ill = !alu_ok;
                w = (a == 1 ? 32'h4000_0000 : 32'h0) | (r2 << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | 32'h33;
            end
            1: begin
                ill = !alu_ok || a == 1 || imm < -2048 || imm > 2047;
                w = ((u & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
            end
            2: begin
                ill = imm < -2048 || imm > 2047;
                w = ((u & 32'hFFF) << 20) | (r1 << 15) | (32'd2 << 12) | (d << 7) | 32'h03;
            end
            3: begin
                ill = imm < -2048 || imm > 2047;
                w = (((u >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (32'd2 << 12)
                    | ((u & 32'h1F) << 7) | 32'h23;
            end
            4: begin
                ill = imm < -4096 || imm > 4095 || (imm % 2) != 0;
                w = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (r2 << 20) | (r1 << 15)
                    | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7) | 32'h63;
            end
            5: begin
                ill = (imm % 2) != 0;
                w = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
                    | (((u >> 12) & 32'hFF) << 12) | (d << 7) | 32'h6F;
            end
            default: ill = 1;
        endcase
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_addr = 0; exp_cnt = 0; exp_err = 0;
    endtask

    // Present one request, complete the handshake, check the outcome.
    task automatic send(input logic [2:0] k, input logic [2:0] a, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input int imm,
                        input logic last, input logic [31:0] exp_word, input bit exp_ill,
                        input bit start_in_write, input string nm);
        int n;
        req_kind = k; req_alu = a; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_imm = imm[20:0]; req_last = last; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++; n_err++;
            $display("FAIL %s_ready_timeout: ready stayed 0, expected 1", nm);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_last = 1'b0;
        if (!exp_ill) begin
            chk({nm, "_we"}, 32'(imem_we), 32'd1);
            chk({nm, "_addr"}, 32'(imem_addr), 32'(exp_addr));
            chk({nm, "_wdata"}, imem_wdata, exp_word);
            if (start_in_write) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            exp_addr++; exp_cnt++;
            chk({nm, "_count"}, 32'(count), 32'(exp_cnt));
            chk({nm, "_done"}, 32'(done), 32'(last));
            if (last) chk({nm, "_ready_done"}, 32'(req_ready), 32'd0);
        end else begin
            exp_err = 1;
            chk({nm, "_we_rej"}, 32'(imem_we), 32'd0);
            chk({nm, "_err"}, 32'(err), 32'd1);
            chk({nm, "_count_rej"}, 32'(count), 32'(exp_cnt));
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        bit          ill;
        int          k, a, imm, sel, n;

        reset_n = 1'b0; start = 1'b0; req_valid = 1'b0; req_last = 1'b0;
        req_kind = 0; req_alu = 0; req_rd = 0; req_rs1 = 0; req_rs2 = 0; req_imm = 0;
        d2_start = 1'b0; d2_valid = 1'b0; d2_last = 1'b0;
        d2_kind = 3'd1; d2_alu = 3'd0; d2_rd = 0; d2_rs1 = 0; d2_rs2 = 0; d2_imm = 0;

        vecs[0]  = '{3'd1, 3'd0, 5'd1, 5'd0, 5'd0, 5,     1'b0, 32'h00500093, 1'b0};
        vecs[1]  = '{3'd0, 3'd1, 5'd3, 5'd1, 5'd2, 0,     1'b0, 32'h402081B3, 1'b0};
        vecs[2]  = '{3'd3, 3'd0, 5'd0, 5'd0, 5'd2, 8,     1'b0, 32'h00202423, 1'b0};
        vecs[3]  = '{3'd4, 3'd0, 5'd0, 5'd1, 5'd2, -4,    1'b0, 32'hFE208EE3, 1'b0};
        vecs[4]  = '{3'd1, 3'd0, 5'd1, 5'd0, 5'd0, 2048,  1'b0, 32'h0,        1'b1};
        vecs[5]  = '{3'd4, 3'd0, 5'd0, 5'd1, 5'd2, 3,     1'b0, 32'h0,        1'b1};
        vecs[6]  = '{3'd0, 3'd2, 5'd5, 5'd6, 5'd7, 0,     1'b0, 32'h007372B3, 1'b0};
        vecs[7]  = '{3'd6, 3'd0, 5'd1, 5'd1, 5'd1, 0,     1'b0, 32'h0,        1'b1};
        vecs[8]  = '{3'd1, 3'd1, 5'd1, 5'd1, 5'd1, 0,     1'b0, 32'h0,        1'b1};
        vecs[9]  = '{3'd0, 3'd4, 5'd1, 5'd1, 5'd1, 0,     1'b0, 32'h0,        1'b1};
        vecs[10] = '{3'd2, 3'd0, 5'd4, 5'd2, 5'd0, -2048, 1'b0, 32'h80012203, 1'b0};
        vecs[11] = '{3'd1, 3'd5, 5'd2, 5'd3, 5'd0, 2047,  1'b0, 32'h7FF1A113, 1'b0};
        vecs[12] = '{3'd4, 3'd0, 5'd0, 5'd0, 5'd0, 4094,  1'b0, 32'h7E000FE3, 1'b0};
        vecs[13] = '{3'd5, 3'd0, 5'd1, 5'd0, 5'd0, 7,     1'b0, 32'h0,        1'b1};
        vecs[14] = '{3'd5, 3'd0, 5'd0, 5'd0, 5'd0, 8,     1'b1, 32'h0080006F, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", 32'(imem_we), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ready", 32'(req_ready), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", 32'(req_ready), 0);

        // Table of known encodings
        pulse_start();
        chk("start_ready", 32'(req_ready), 1);
        foreach (vecs[i]) begin
            send(vecs[i].kind, vecs[i].alu, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                 vecs[i].last, vecs[i].word, vecs[i].ill, 1'b0, $sformatf("vec%0d", i));
        end
        repeat (2) @(posedge clk);
        #1;
        chk("tbl_done_hold", 32'(done), 1);
        chk("tbl_err_sticky", 32'(err), 1);
        chk("tbl_count_final", 32'(count), 32'(exp_cnt));

        // Randomized requests against the reference model
        pulse_start();
        chk("rnd_err_clr", 32'(err), 0);
        chk("rnd_count_clr", 32'(count), 0);
        chk("rnd_done_clr", 32'(done), 0);
        for (int i = 0; i < 40; i++) begin
            k = int'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0: a = 0; 1: a = 1; 2: a = 2; 3: a = 5;
                default: a = int'($urandom_range(0, 7));
            endcase
            sel = int'($urandom_range(0, 3));
            case (sel)
                0: imm = int'($urandom_range(0, 80)) - 40;
                1: imm = int'($urandom_range(0, 2097151)) - 1048576;
                2: begin
                    case ($urandom_range(0, 7))
                        0: imm = -2048; 1: imm = 2047; 2: imm = 2048; 3: imm = -2049;
                        4: imm = -4096; 5: imm = 4095; 6: imm = 4094; default: imm = -4098;
                    endcase
                end
                default: imm = int'($urandom_range(0, 10000)) - 5000;
            endcase
            if (i == 39) begin
                k = 1; a = 0; imm = 12;
            end
            model(k, a, i % 32, (i * 7) % 32, (i * 3) % 32, imm, w, ill);
            send(3'(k), 3'(a), 5'(i % 32), 5'((i * 7) % 32), 5'((i * 3) % 32), imm,
                 (i == 39), w, ill, 1'b0, $sformatf("rnd%0d", i));
        end
        chk("rnd_err_final", 32'(err), 32'(exp_err));

        // start in LOAD is ignored; start coincident with the final write
        pulse_start();
        model(1, 0, 1, 0, 0, 1, w, ill);
        send(3'd1, 3'd0, 5'd1, 5'd0, 5'd0, 1, 1'b0, w, 1'b0, 1'b0, "seqA");
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_in_load_count", 32'(count), 1);
        model(1, 0, 2, 0, 0, 2, w, ill);
        send(3'd1, 3'd0, 5'd2, 5'd0, 5'd0, 2, 1'b0, w, 1'b0, 1'b0, "seqB");
        model(1, 0, 3, 0, 0, 3, w, ill);
        send(3'd1, 3'd0, 5'd3, 5'd0, 5'd0, 3, 1'b1, w, 1'b0, 1'b1, "seqC");
        @(posedge clk); #1;
        chk("start_in_write_done", 32'(done), 1);
        chk("start_in_write_count", 32'(count), 3);

        // Full memory on the ADDR_W=2 instance
        d2_start = 1'b1;
        @(posedge clk); #1;
        d2_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d2_rd = 5'(i + 1); d2_imm = 21'(i); d2_valid = 1'b1;
            n = 0;
            @(negedge clk);
            while (!d2_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!d2_ready) begin
                n_checks++; n_err++;
                $display("FAIL full_ready_timeout%0d: ready stayed 0, expected 1", i);
            end
            @(posedge clk); #1;
            d2_valid = 1'b0;
            model(1, 0, i + 1, 0, 0, i, w, ill);
            chk($sformatf("full_we%0d", i), 32'(d2_we), 1);
            chk($sformatf("full_addr%0d", i), 32'(d2_addr), 32'(i));
            chk($sformatf("full_wdata%0d", i), d2_wdata, w);
            @(posedge clk); #1;
            chk($sformatf("full_count%0d", i), 32'(d2_count), 32'(i + 1));
        end
        chk("full_flag", 32'(d2_full), 1);
        chk("full_done", 32'(d2_done), 1);
        chk("full_err", 32'(d2_err), 0);
        d2_rd = 5'd5; d2_imm = 21'd4; d2_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("full_5th_ready", 32'(d2_ready), 0);
            chk("full_5th_we", 32'(d2_we), 0);
        end
        chk("full_5th_count", 32'(d2_count), 4);
        d2_valid = 1'b0;
        @(posedge clk); #1;
        d2_start = 1'b1;
        @(posedge clk); #1;
        d2_start = 1'b0;
        chk("restart_addr", 32'(d2_addr), 0);
        chk("restart_full", 32'(d2_full), 0);
        chk("restart_count", 32'(d2_count), 0);
        chk("restart_ready", 32'(d2_ready), 1);
        chk("restart_done", 32'(d2_done), 0);

        // Asynchronous reset while a write is in flight
        pulse_start();
        model(1, 0, 1, 0, 0, 9, w, ill);
        send(3'd1, 3'd0, 5'd1, 5'd0, 5'd0, 9, 1'b0, w, 1'b0, 1'b0, "prerst");
        req_kind = 3'd1; req_alu = 3'd0; req_rd = 5'd9; req_rs1 = 5'd0; req_imm = 21'd3;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("inwrite_we", 32'(imem_we), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_we", 32'(imem_we), 0);
        chk("arst_addr", 32'(imem_addr), 0);
        chk("arst_wdata", imem_wdata, 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_ready", 32'(req_ready), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_we", 32'(imem_we), 0);
        pulse_start();
        model(1, 0, 1, 0, 0, 7, w, ill);
        send(3'd1, 3'd0, 5'd1, 5'd0, 5'd0, 7, 1'b0, w, 1'b0, 1'b0, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
